// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Lookups are combinational. On a miss, fetch stalls while the whole line is
// refilled from memory in a single beat. flush_i invalidates every line; a
// flush that arrives during a refill lets the refill finish but leaves the line invalid.
module icache #(
   parameter int ADDR_SIZE       = 32,
   parameter int INSTR_SIZE      = 32,
   parameter int CACHE_LINE_SIZE = 64,
   parameter int CACHE_NUM_LINES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid_i,
   input  logic [ADDR_SIZE-1:0]         req_addr_i,
   output logic [INSTR_SIZE-1:0]        instr_o,
   output logic                         instr_valid_o,
   output logic                         stall_o,
   input  logic                         flush_i,
   output logic                         mem_req_o,
   output logic [ADDR_SIZE-1:0]         mem_addr_o,
   input  logic                         mem_rsp_valid_i,
   input  logic [CACHE_LINE_SIZE*8-1:0] mem_rsp_data_i
);

   localparam int OFFSET_W = $clog2(CACHE_LINE_SIZE);
   localparam int INDEX_W  = $clog2(CACHE_NUM_LINES);
   localparam int TAG_W    = ADDR_SIZE - OFFSET_W - INDEX_W;
   localparam int LINE_W   = CACHE_LINE_SIZE * 8;
   localparam int WORDS    = LINE_W / INSTR_SIZE;
   localparam int BYTE_W   = $clog2(INSTR_SIZE / 8);
   localparam int WSEL_W   = OFFSET_W - BYTE_W;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                     state_reg;
   logic                       drop_reg;
   logic                       mem_req_reg;
   logic [ADDR_SIZE-1:0]       miss_addr_reg;
   logic [CACHE_NUM_LINES-1:0] valid_reg;

   // Tag and data arrays: read combinationally, written only by a refill.
   logic [TAG_W-1:0]  tag_mem  [CACHE_NUM_LINES];
   logic [LINE_W-1:0] data_mem [CACHE_NUM_LINES];

   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   logic [WSEL_W-1:0]  req_wsel;
   logic [INDEX_W-1:0] refill_index;
   logic [TAG_W-1:0]   refill_tag;
   logic               lookup_match;
   logic               hit;
   logic               refill_done;
   logic               unused_byte_bits;

   assign req_index    = req_addr_i[OFFSET_W +: INDEX_W];
   assign req_tag      = req_addr_i[ADDR_SIZE-1 -: TAG_W];
   assign req_wsel     = req_addr_i[BYTE_W +: WSEL_W];
   assign refill_index = miss_addr_reg[OFFSET_W +: INDEX_W];
   assign refill_tag   = miss_addr_reg[ADDR_SIZE-1 -: TAG_W];

   // Byte-within-word bits play no part in the lookup (no misalignment check).
   assign unused_byte_bits = ^req_addr_i[BYTE_W-1:0];

   // A flush in IDLE masks the hit so the cycle behaves as a stall with no refill.
   assign lookup_match = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
   assign hit          = req_valid_i && (state_reg == IDLE) && lookup_match && !flush_i;
   assign refill_done  = (state_reg == MISS) && mem_rsp_valid_i;

   assign instr_valid_o = hit;
   assign stall_o       = (req_valid_i && !hit) || (state_reg == MISS);
   assign mem_req_o     = mem_req_reg;
   assign mem_addr_o    = miss_addr_reg;

   // Split the indexed line into words; the word select picks one every cycle.
   logic [LINE_W-1:0]     line_sel;
   logic [INSTR_SIZE-1:0] line_words [WORDS];

   assign line_sel = data_mem[req_index];

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
         assign line_words[gi] = line_sel[gi*INSTR_SIZE +: INSTR_SIZE];
      end
   endgenerate

   assign instr_o = line_words[req_wsel];

   // Refill FSM with its registered outputs, the valid bits and the drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         drop_reg      <= 1'b0;
         mem_req_reg   <= 1'b0;
         miss_addr_reg <= '0;
         valid_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid_i && !hit && !flush_i) begin
                  miss_addr_reg <= {req_addr_i[ADDR_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  mem_req_reg   <= 1'b1;
                  state_reg     <= MISS;
               end
            end
            MISS: begin
               if (flush_i) begin
                  drop_reg <= 1'b1;
               end
               if (mem_rsp_valid_i) begin
                  // A flush seen during this refill leaves the new line invalid.
                  valid_reg[refill_index] <= !drop_reg;
                  drop_reg                <= 1'b0;
                  mem_req_reg             <= 1'b0;
                  state_reg               <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         // The flush overrides any valid bit set by a refill on this same edge.
         if (flush_i) begin
            valid_reg <= '0;
         end
      end
   end

   // Array write: the refill always writes tag and data, even when it is dropped.
   always_ff @(posedge clk) begin
      if (!rst && refill_done) begin
         data_mem[refill_index] <= mem_rsp_data_i;
         tag_mem[refill_index]  <= refill_tag;
      end
   end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache. A reference model tracks which
// line address occupies each slot and which memory "epoch" its data came from.
// A memory responder answers refills after a programmable latency.
module tb_icache;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic [31:0]  req_addr = '0;
   logic         flush = 1'b0;
   logic         mem_rsp_valid = 1'b0;
   logic [511:0] mem_rsp_data = '0;
   logic [31:0]  instr;
   logic         instr_valid;
   logic         stall;
   logic         mem_req;
   logic [31:0]  mem_addr;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Memory side: latency, a content epoch (bumped to model self-modifying code), manual pulse.
   int          mem_lat    = 0;
   int          epoch      = 0;
   int          wait_cnt   = 0;
   bit          manual_rsp = 1'b0;
   logic [31:0] manual_line = '0;

   // Reference model: one entry per slot.
   bit          m_valid [4];
   logic [31:0] m_line  [4];
   int          m_epoch [4];

   icache dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid),
      .req_addr_i      (req_addr),
      .instr_o         (instr),
      .instr_valid_o   (instr_valid),
      .stall_o         (stall),
      .flush_i         (flush),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_rsp_valid_i (mem_rsp_valid),
      .mem_rsp_data_i  (mem_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] line, input int k, input int ep);
      logic [31:0] r;
      if (line == 32'h0000_1000 && k == 0 && ep == 0) return 32'h0050_0093;
      r = line ^ (32'(k) * 32'h0100_0193) ^ (32'(ep) * 32'h9E37_79B1) ^ 32'h13;
      return r;
   endfunction

   function automatic logic [511:0] build_line(input logic [31:0] line, input int ep);
      logic [511:0] d;
      d = '0;
      for (int k = 0; k < 16; k++) d[32*k +: 32] = mem_word(line, k, ep);
      return d;
   endfunction

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return {a[31:6], 6'b0};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
   endtask

   task automatic model_fill(input logic [31:0] a);
      m_valid[a[7:6]] = 1'b1;
      m_line[a[7:6]]  = line_of(a);
      m_epoch[a[7:6]] = epoch;
   endtask

   // Memory responder: answers mem_req after mem_lat request cycles, data taken from mem_addr.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (manual_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = build_line(manual_line, epoch);
            wait_cnt      = 0;
         end else if (mem_req && !rst) begin
            if (wait_cnt == mem_lat) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = build_line(mem_addr, epoch);
               wait_cnt      = 0;
            end else begin
               mem_rsp_valid = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_rsp_valid = 1'b0;
            wait_cnt      = 0;
         end
      end
   end

   // One fetch transaction: hold the address until instr_valid, check timing and data.
   task automatic fetch(input logic [31:0] a, input int lat, input bit fresh);
      bit          exp_hit;
      bit          got;
      int          stalls;
      int          reqs;
      logic [31:0] seen_addr;
      logic [31:0] exp_instr;
      if (fresh) next_cycle();
      exp_hit   = m_valid[a[7:6]] && (m_line[a[7:6]] == line_of(a));
      mem_lat   = lat;
      req_valid = 1'b1;
      req_addr  = a;
      got = 1'b0; stalls = 0; reqs = 0; seen_addr = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (instr_valid) begin
            got = 1'b1;
            break;
         end
         if (stall) stalls++;
         if (mem_req) begin
            if (reqs == 0) seen_addr = mem_addr;
            reqs++;
         end
      end
      if (!exp_hit) model_fill(a);
      exp_instr = mem_word(m_line[a[7:6]], int'(a[5:2]), m_epoch[a[7:6]]);
      check("fetch_done", 64'(got), 64'd1);
      check("stall_cycles", 64'(stalls), exp_hit ? 64'd0 : 64'(lat + 2));
      check("req_cycles", 64'(reqs), exp_hit ? 64'd0 : 64'(lat + 1));
      if (!exp_hit) check("refill_addr", 64'(seen_addr), 64'(line_of(a)));
      check("instr", 64'(instr), 64'(exp_instr));
      check("hit_no_stall", 64'(stall), 64'd0);
      check("hit_no_req", 64'(mem_req), 64'd0);
      $display("fetch addr=%h lat=%0d exp_hit=%0b stalls=%0d instr=%h", a, lat, exp_hit, stalls, instr);
   endtask

   // Flush in IDLE while a resident-or-not request is presented.
   task automatic flush_idle(input logic [31:0] a);
      next_cycle();
      req_valid = 1'b1;
      req_addr  = a;
      flush     = 1'b1;
      @(negedge clk);
      check("flush_hit_off", 64'(instr_valid), 64'd0);
      check("flush_stall", 64'(stall), 64'd1);
      next_cycle();
      flush     = 1'b0;
      req_valid = 1'b0;
      model_clear();
      epoch++;
      @(negedge clk);
      check("flush_no_refill", 64'(mem_req), 64'd0);
      $display("flush idle addr=%h epoch=%0d", a, epoch);
   endtask

   // Wait (bounded) until the refill request drops; leaves time at posedge+1.
   task automatic wait_req_low(input string tag);
      bit low;
      low = 1'b0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         if (!mem_req) begin
            low = 1'b1;
            break;
         end
      end
      check(tag, 64'(low), 64'd1);
   endtask

   // Flush during a refill (L=2): the address re-misses once, then hits.
   task automatic flush_mid(input logic [31:0] a);
      next_cycle();
      mem_lat   = 2;
      req_valid = 1'b1;
      req_addr  = a;
      next_cycle();
      check("fm_req_up", 64'(mem_req), 64'd1);
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      model_clear();
      wait_req_low("fm_refill_end");
      $display("flush mid-miss addr=%h", a);
      fetch(a, 2, 1'b0);
      fetch(a, 2, 1'b1);
   endtask

   // Redirect while in MISS: old line fills, the new address then misses itself.
   task automatic redirect(input logic [31:0] a, input logic [31:0] b, input int lat);
      next_cycle();
      mem_lat   = lat;
      req_valid = 1'b1;
      req_addr  = a;
      next_cycle();
      check("rd_req_up", 64'(mem_req), 64'd1);
      check("rd_addr", 64'(mem_addr), 64'(line_of(a)));
      req_addr = b;
      wait_req_low("rd_refill_end");
      model_fill(a);
      $display("redirect %h -> %h lat=%0d", a, b, lat);
      fetch(b, lat, 1'b0);
      fetch(a, lat, 1'b1);
   endtask

   // Reset one cycle after mem_req rises, then a late response that must be ignored.
   task automatic reset_mid(input logic [31:0] a);
      next_cycle();
      mem_lat   = 5;
      req_valid = 1'b1;
      req_addr  = a;
      next_cycle();
      check("rm_req_up", 64'(mem_req), 64'd1);
      next_cycle();
      rst       = 1'b1;
      req_valid = 1'b0;
      next_cycle();
      rst         = 1'b0;
      manual_line = line_of(a);
      manual_rsp  = 1'b1;
      model_clear();
      @(negedge clk);
      check("rm_req_low", 64'(mem_req), 64'd0);
      next_cycle();
      manual_rsp = 1'b0;
      @(negedge clk);
      check("rm_still_low", 64'(mem_req), 64'd0);
      $display("reset mid-refill addr=%h", a);
      fetch(a, 1, 1'b1);
   endtask

   initial begin
      logic [31:0] ra;
      int          r;
      model_clear();
      // Reset state: held in reset with a request present.
      req_valid = 1'b1;
      req_addr  = 32'h0000_1000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_instr_valid", 64'(instr_valid), 64'd0);
      check("rst_stall_req", 64'(stall), 64'd1);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      req_valid = 1'b0;
      #1;
      check("rst_stall_idle", 64'(stall), 64'd0);
      next_cycle();
      rst = 1'b0;

      // Cold miss, spatial hit, conflict eviction.
      fetch(32'h0000_1000, 3, 1'b1);
      check("cold_word0", 64'(instr), 64'h0050_0093);
      fetch(32'h0000_103C, 0, 1'b1);
      fetch(32'h0000_1040, 1, 1'b1);
      fetch(32'h0000_1100, 2, 1'b1);
      fetch(32'h0000_1000, 0, 1'b1);
      fetch(32'h0000_1040, 4, 1'b1);

      // Fill all lines, flush in IDLE, every address misses again with new content.
      fetch(32'h0000_1080, 1, 1'b1);
      fetch(32'h0000_10C4, 0, 1'b1);
      flush_idle(32'h0000_1000);
      fetch(32'h0000_1000, 1, 1'b1);
      fetch(32'h0000_1044, 0, 1'b1);
      fetch(32'h0000_1088, 2, 1'b1);
      fetch(32'h0000_10CC, 1, 1'b1);

      flush_mid(32'h0000_1100);

      flush_idle(32'h0000_1200);
      redirect(32'h0000_1000, 32'h0000_1044, 1);

      flush_idle(32'h0000_1000);
      reset_mid(32'h0000_1000);

      // Randomized traffic over a small set of conflicting lines.
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 9);
         ra = (32'($urandom_range(16, 18)) << 8) | (32'($urandom_range(0, 3)) << 6)
            | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if (r == 0) flush_idle(ra);
         else fetch(ra, $urandom_range(0, 4), 1'b1);
      end

      next_cycle();
      req_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the memory arbiter. It uses the global cache geometry of 4 lines × 64 bytes. Lookups are combinational, so a hit returns the instruction in the same cycle. A miss stalls fetch while a two-state FSM fetches the whole line from memory in one beat. It also supports a whole-cache flush for fence.i and self-modifying-code handling.

## Interface
Parameters:
- ADDR_SIZE, 32, address width
- INSTR_SIZE, 32, instruction width
- CACHE_LINE_SIZE, 64, line size in bytes
- CACHE_NUM_LINES, 4, number of lines (power of two)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  fetch requests an instruction this cycle
- req_addr_i  in  ADDR_SIZE  fetch byte address
- instr_o  out  INSTR_SIZE  instruction word selected from the cache array
- instr_valid_o  out  1  instr_o valid (hit)
- stall_o  out  1  fetch must hold req_addr_i
- flush_i  in  1  invalidate all lines
- mem_req_o  out  1  line refill request, level-held
- mem_addr_o  out  ADDR_SIZE  line-aligned refill address
- mem_rsp_valid_i  in  1  refill data present, one-cycle pulse
- mem_rsp_data_i  in  CACHE_LINE_SIZE*8  full line data

## Operation

Address split, using the defaults:
- offset = addr[5:0]; word select = addr[5:2]
- index = addr[7:6]
- tag = addr[31:8], width 24
- addr[1:0] is ignored (no misalignment check)

Storage:
- Per line: valid bit, tag, and a 512-bit data field.
- Word k of a line occupies data bits [32k+31:32k], which is byte offset 4k (little-endian word order).

Hit path (combinational):
- hit = req_valid_i & state==IDLE & valid[index] & tag[index]==tag.
- instr_o = word[word select] of line[index] at all times.
- instr_valid_o = hit.

Stall:
- stall_o = req_valid_i & !hit, or state==MISS.

FSM states:
- IDLE
  - On req_valid_i & !hit & !flush_i: latch miss_addr = {req_addr_i[31:6], 6'b0}, go to MISS.
- MISS
  - mem_req_o = 1 and mem_addr_o = miss_addr, held until the response arrives.
  - On mem_rsp_valid_i: write the data and tag into line miss_addr[7:6]; set valid unless drop is set; clear drop; go to IDLE.
- mem_req_o is 0 in IDLE.
- mem_rsp_valid_i is ignored in IDLE.

Flush:
- flush_i clears every valid bit at the next edge.
- In IDLE, a flush takes priority over starting a miss, and hit is forced to 0 that cycle.
- In MISS, flush sets drop. The in-flight refill still completes and writes the line, but valid stays 0, so the request re-misses.

Request changes during a miss:
- req_addr_i may change while in MISS (e.g. a redirect).
- The refill always uses the latched miss_addr.
- After returning to IDLE, the current address is looked up fresh.

Write policy:
- Read-only: there is no write port.
- Memory coherence is handled by software via flush_i.

## Timing

- Reset values:
  - state = IDLE, drop = 0, all valid = 0, mem_req_o = 0, mem_addr_o = 0.
  - instr_valid_o = 0.
  - stall_o = req_valid_i (every access misses after reset).
- Hit latency is 0 cycles: instr_valid_o is asserted in the same cycle as req_valid_i.
- Miss timeline:
  - Miss detected in cycle c.
  - mem_req_o is high from c+1.
  - The response arrives at c+1+L, where L ≥ 0 means the memory may respond in the first request cycle.
  - The line is valid at edge c+2+L, so instr_valid_o rises in cycle c+2+L.
  - Miss penalty = L+2 stall cycles.
- mem_req_o drops in the cycle after the response.
- At most one outstanding refill exists at any time.
- Reset asserted in MISS:
  - The FSM returns to IDLE and mem_req_o goes low at the next edge.
  - A response that arrives later is ignored.
  - No line is marked valid.
- Flush and response in the same MISS cycle: the line is written but remains invalid.

## Test plan
- Cold miss: after reset, fetch 0x00001000 with memory L=3 and line word0=0x00500093 → stall_o high for 5 cycles, mem_addr_o=0x00001000 and mem_req_o high for 4 cycles, then instr_valid_o=1 with instr_o=0x00500093.
- Spatial hit: after the above, fetch 0x0000103C → same-cycle hit, instr_o = word15 of the line, mem_req_o stays 0.
- Conflict eviction: fetch 0x00001100 (index 0, tag 0x11) → miss and refill with mem_addr_o=0x00001100. Refetch 0x00001000 → miss again. A fetch to 0x00001040 (index 1) is unaffected.
- Flush: fill lines 0–3, pulse flush_i in IDLE → the next fetch of each address misses. Pulse flush_i during a MISS with L=2 → the refill completes, the same address misses once more, then hits.
- Redirect during miss: miss on 0x00001000, change req_addr_i to 0x00001044 while in MISS → the refill writes 0x00001000's line, then a new miss is issued for 0x00001040.
- Reset mid-refill: assert rst 1 cycle after mem_req_o rises, then deliver mem_rsp_valid_i → mem_req_o is 0 next cycle, and a fetch of 0x00001000 still misses.
